// File: rtl/calc_pkg.sv
// Shared types and widths for the calc1 port driver.
package calc_pkg;

   localparam int unsigned CALC_DATA_W = 32;
   localparam int unsigned CALC_CMD_W  = 4;
   localparam int unsigned CALC_RESP_W = 2;

   typedef enum logic [CALC_CMD_W-1:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [CALC_RESP_W-1:0] {
      RESP_NONE    = 2'd0,
      RESP_OK      = 2'd1,
      RESP_OFLOW   = 2'd2,
      RESP_INVALID = 2'd3
   } resp_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND_OP1  = 3'd1,
      ST_SEND_OP2  = 3'd2,
      ST_WAIT_RESP = 3'd3,
      ST_DONE      = 3'd4
   } drv_state_e;

endpackage

// File: rtl/calc_port_driver_if.sv
// Host-side request/response handshake bundle for calc_port_driver.
interface calc_port_driver_if #(
   parameter int unsigned TAG_W = 4
) ();
   import calc_pkg::*;

   logic                   req_valid;
   logic                   req_ready;
   logic [CALC_CMD_W-1:0]  req_cmd;
   logic [CALC_DATA_W-1:0] req_op1;
   logic [CALC_DATA_W-1:0] req_op2;
   logic [TAG_W-1:0]       req_tag;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [CALC_RESP_W-1:0] rsp_resp;
   logic [CALC_DATA_W-1:0] rsp_data;
   logic [TAG_W-1:0]       rsp_tag;
   logic                   rsp_timeout;

   // Host side: issues requests, consumes results.
   modport master (
      output req_valid, req_cmd, req_op1, req_op2, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout
   );

   // Driver side.
   modport slave (
      input  req_valid, req_cmd, req_op1, req_op2, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout
   );

endinterface

// File: rtl/calc_drv_timer.sv
// Wait-for-response timer: cleared by load, counts while tick is high,
// expired is a registered flag that is set while the count equals TIMEOUT_CYCLES-1.
module calc_drv_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic c_clk,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc_c;

   assign cnt_inc_c = cnt_q + CNT_W'(1);

   // Count register with expiry flag tracking the value being loaded.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         cnt_q   <= '0;
         expired <= 1'b0;
      end else if (load) begin
         cnt_q   <= '0;
         expired <= (TIMEOUT_CYCLES == 1);
      end else if (tick) begin
         cnt_q   <= cnt_inc_c;
         expired <= (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

endmodule

// File: rtl/calc_port_driver.sv
// Upstream request driver for one calc1 port: serialises {cmd,op1,op2} onto the
// two-cycle calc1 protocol, waits for out_resp and returns {resp,data,tag}.
// Optional wait-for-response timeout: define CALC_DRV_TIMEOUT_EN.
module calc_port_driver
   import calc_pkg::*;
#(
   parameter int unsigned TAG_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                   c_clk,
   input  logic                   reset,
   calc_port_driver_if.slave      host,
   output logic [CALC_CMD_W-1:0]  dut_cmd,
   output logic [CALC_DATA_W-1:0] dut_data,
   input  logic [CALC_RESP_W-1:0] dut_resp,
   input  logic [CALC_DATA_W-1:0] dut_rdata,
   output logic                   err_spurious
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("calc_port_driver: TIMEOUT_CYCLES must be nonzero");
   end

   drv_state_e             state_q, state_d;

   logic [CALC_CMD_W-1:0]  cmd_q;
   logic [CALC_DATA_W-1:0] op2_q;
   logic [TAG_W-1:0]       tag_q;

   logic                   req_ready_q,   req_ready_d;
   logic                   rsp_valid_q,   rsp_valid_d;
   logic [CALC_RESP_W-1:0] rsp_resp_q,    rsp_resp_d;
   logic [CALC_DATA_W-1:0] rsp_data_q,    rsp_data_d;
   logic [TAG_W-1:0]       rsp_tag_q,     rsp_tag_d;
   logic                   rsp_timeout_q, rsp_timeout_d;
   logic [CALC_CMD_W-1:0]  dut_cmd_q,     dut_cmd_d;
   logic [CALC_DATA_W-1:0] dut_data_q,    dut_data_d;
   logic                   err_spur_q,    err_spur_d;

   logic                   accept_c;
   logic                   tmr_expired;

   assign accept_c = host.req_valid && req_ready_q;

`ifdef CALC_DRV_TIMEOUT_EN
   logic tmr_load_c;
   logic tmr_tick_c;

   assign tmr_load_c = (state_q == ST_SEND_OP2) && (cmd_q != CMD_NOP);
   assign tmr_tick_c = (state_q == ST_WAIT_RESP);

   calc_drv_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .c_clk   (c_clk),
      .reset   (reset),
      .load    (tmr_load_c),
      .tick    (tmr_tick_c),
      .expired (tmr_expired)
   );
`else
   assign tmr_expired = 1'b0;
`endif

   // Next state and next registered outputs.
   always_comb begin
      state_d       = state_q;
      req_ready_d   = 1'b0;
      rsp_valid_d   = rsp_valid_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_data_d    = rsp_data_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_timeout_d = rsp_timeout_q;
      dut_cmd_d     = '0;
      dut_data_d    = '0;
      err_spur_d    = err_spur_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d    = ST_SEND_OP1;
               dut_cmd_d  = host.req_cmd;
               dut_data_d = host.req_op1;
            end
         end
         ST_SEND_OP1: begin
            state_d    = ST_SEND_OP2;
            dut_data_d = op2_q;
         end
         ST_SEND_OP2: begin
            if (cmd_q == CMD_NOP) begin
               // NOP gets no answer from calc1; complete locally.
               state_d       = ST_DONE;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = RESP_NONE;
               rsp_data_d    = '0;
               rsp_tag_d     = tag_q;
               rsp_timeout_d = 1'b0;
            end else begin
               state_d = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            // A response wins over a timeout expiring in the same cycle.
            if (dut_resp != RESP_NONE) begin
               state_d       = ST_DONE;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = dut_resp;
               rsp_data_d    = (dut_resp == RESP_OK) ? dut_rdata : '0;
               rsp_tag_d     = tag_q;
               rsp_timeout_d = 1'b0;
            end else if (tmr_expired) begin
               state_d       = ST_DONE;
               rsp_valid_d   = 1'b1;
               rsp_resp_d    = RESP_NONE;
               rsp_data_d    = '0;
               rsp_tag_d     = tag_q;
               rsp_timeout_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (rsp_valid_q && host.rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);

      if ((dut_resp != RESP_NONE) && (state_q != ST_WAIT_RESP)) begin
         err_spur_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_resp_q    <= '0;
         rsp_data_q    <= '0;
         rsp_tag_q     <= '0;
         rsp_timeout_q <= 1'b0;
         dut_cmd_q     <= '0;
         dut_data_q    <= '0;
         err_spur_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_data_q    <= rsp_data_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_timeout_q <= rsp_timeout_d;
         dut_cmd_q     <= dut_cmd_d;
         dut_data_q    <= dut_data_d;
         err_spur_q    <= err_spur_d;
      end
   end

   // Transaction capture at handshake.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         cmd_q <= '0;
         op2_q <= '0;
         tag_q <= '0;
      end else if (accept_c) begin
         cmd_q <= host.req_cmd;
         op2_q <= host.req_op2;
         tag_q <= host.req_tag;
      end
   end

   assign host.req_ready   = req_ready_q;
   assign host.rsp_valid   = rsp_valid_q;
   assign host.rsp_resp    = rsp_resp_q;
   assign host.rsp_data    = rsp_data_q;
   assign host.rsp_tag     = rsp_tag_q;
   assign host.rsp_timeout = rsp_timeout_q;
   assign dut_cmd          = dut_cmd_q;
   assign dut_data         = dut_data_q;
   assign err_spurious     = err_spur_q;

endmodule

// File: tb/tb_calc_port_driver.sv
// Scoreboard bench for calc_port_driver; the bench plays the calc1 port.
// Timeout scenario is exercised when CALC_DRV_TIMEOUT_EN is defined.
module tb_calc_port_driver;
   import calc_pkg::*;

   localparam int unsigned TAG_W = 4;
   localparam int unsigned TMO   = 16;

   typedef struct packed {
      logic [1:0]       resp;
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic             tmo;
   } exp_t;

   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  dut_cmd;
   logic [31:0] dut_data;
   logic [1:0]  dut_resp;
   logic [31:0] dut_rdata;
   logic        err_spurious;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   calc_port_driver_if #(.TAG_W(TAG_W)) host_if ();

   calc_port_driver #(
      .TAG_W          (TAG_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .host         (host_if),
      .dut_cmd      (dut_cmd),
      .dut_data     (dut_data),
      .dut_resp     (dut_resp),
      .dut_rdata    (dut_rdata),
      .err_spurious (err_spurious)
   );

   always #5 c_clk = ~c_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference calc1 behaviour: {resp, data}.
   function automatic logic [33:0] calc_ref(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [32:0] s;
      case (cmd)
         4'd0: return {2'b00, 32'd0};
         4'd1: begin
            s = {1'b0, a} + {1'b0, b};
            return s[32] ? {2'b10, 32'd0} : {2'b01, s[31:0]};
         end
         4'd2: return (b > a) ? {2'b10, 32'd0} : {2'b01, a - b};
         4'd5: return {2'b01, a << b[4:0]};
         4'd6: return {2'b01, a >> b[4:0]};
         default: return {2'b11, 32'd0};
      endcase
   endfunction

   task automatic wait_ready();
      int k;
      k = 0;
      while (!host_if.req_ready && k < 20) begin
         @(negedge c_clk);
         k++;
      end
      check("req_ready", 64'(host_if.req_ready), 64'd1);
   endtask

   // lat<0: calc1 stays silent. hold: cycles rsp_ready is held low in DONE.
   task automatic do_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [TAG_W-1:0] tag, input int lat, input int hold);
      logic [33:0] ref_v;
      exp_t        e;
      int          k;
      ref_v = calc_ref(cmd, op1, op2);
      wait_ready();
      host_if.req_valid = 1'b1;
      host_if.req_cmd   = cmd;
      host_if.req_op1   = op1;
      host_if.req_op2   = op2;
      host_if.req_tag   = tag;
      e.resp = (lat < 0) ? 2'b00 : ref_v[33:32];
      e.data = (e.resp == 2'b01) ? ref_v[31:0] : 32'd0;
      e.tag  = tag;
      e.tmo  = (lat < 0);
      exp_q.push_back(e);

      @(negedge c_clk);
      host_if.req_valid = 1'b0;
      host_if.req_op1   = 32'hA5A5_A5A5;
      check("op1_cmd", 64'(dut_cmd), 64'(cmd));
      check("op1_data", 64'(dut_data), 64'(op1));
      check("busy", 64'(host_if.req_ready), 64'd0);

      @(negedge c_clk);
      check("op2_cmd", 64'(dut_cmd), 64'd0);
      check("op2_data", 64'(dut_data), 64'(op2));

      @(negedge c_clk);
      if (cmd == 4'd0) begin
         check("nop_valid", 64'(host_if.rsp_valid), 64'd1);
      end else begin
         check("quiet_cmd", 64'(dut_cmd), 64'd0);
         check("quiet_data", 64'(dut_data), 64'd0);
         check("no_early_rsp", 64'(host_if.rsp_valid), 64'd0);
         if (lat < 0) begin
            k = 0;
            while (!host_if.rsp_valid && k < 40) begin
               @(negedge c_clk);
               k++;
            end
            check("tmo_latency", 64'(k), 64'(TMO));
         end else begin
            repeat (lat) @(negedge c_clk);
            dut_resp  = ref_v[33:32];
            dut_rdata = ref_v[31:0];
            @(negedge c_clk);
            dut_resp  = 2'b00;
            dut_rdata = 32'd0;
            check("rsp_rise", 64'(host_if.rsp_valid), 64'd1);
         end
      end

      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 64'(host_if.rsp_valid), 64'd1);
         check("hold_resp", 64'(host_if.rsp_resp), 64'(exp_q[0].resp));
         check("hold_data", 64'(host_if.rsp_data), 64'(exp_q[0].data));
         check("hold_tag", 64'(host_if.rsp_tag), 64'(exp_q[0].tag));
         check("hold_ready", 64'(host_if.req_ready), 64'd0);
         @(negedge c_clk);
      end

      e = exp_q.pop_front();
      check("rsp_valid", 64'(host_if.rsp_valid), 64'd1);
      check("rsp_resp", 64'(host_if.rsp_resp), 64'(e.resp));
      check("rsp_data", 64'(host_if.rsp_data), 64'(e.data));
      check("rsp_tag", 64'(host_if.rsp_tag), 64'(e.tag));
      check("rsp_timeout", 64'(host_if.rsp_timeout), 64'(e.tmo));
      host_if.rsp_ready = 1'b1;
      @(negedge c_clk);
      host_if.rsp_ready = 1'b0;
      check("rsp_drop", 64'(host_if.rsp_valid), 64'd0);
      check("back_idle", 64'(host_if.req_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      host_if.req_valid = 1'b0;
      host_if.req_cmd   = 4'd0;
      host_if.req_op1   = 32'd0;
      host_if.req_op2   = 32'd0;
      host_if.req_tag   = '0;
      host_if.rsp_ready = 1'b0;
      dut_resp          = 2'b00;
      dut_rdata         = 32'd0;

      repeat (3) @(negedge c_clk);
      check("rst_ready", 64'(host_if.req_ready), 64'd0);
      check("rst_valid", 64'(host_if.rsp_valid), 64'd0);
      check("rst_cmd", 64'(dut_cmd), 64'd0);
      check("rst_err", 64'(err_spurious), 64'd0);
      reset = 1'b0;
      @(negedge c_clk);
      check("post_rst_ready", 64'(host_if.req_ready), 64'd1);

      do_txn(4'd1, 32'd5, 32'd1, 4'd3, 2, 0);
      do_txn(4'd0, 32'h64, 32'h27, 4'd5, 0, 0);
      do_txn(4'd1, 32'hFFFF_FFFF, 32'd1, 4'd7, 0, 0);
      do_txn(4'd4, 32'd9, 32'd9, 4'd8, 1, 0);
      do_txn(4'd2, 32'd10, 32'd3, 4'd1, 3, 5);
      do_txn(4'd5, 32'd1, 32'd31, 4'd2, 15, 0);
      do_txn(4'd2, 32'd3, 32'd10, 4'd9, 0, 1);
      do_txn(4'd6, 32'h80, 32'd4, 4'd15, 4, 0);
      for (int i = 0; i < 4; i++) begin
         do_txn((i % 2 == 0) ? 4'd1 : 4'd2, $urandom, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
      end
      check("no_spur_yet", 64'(err_spurious), 64'd0);

`ifdef CALC_DRV_TIMEOUT_EN
      do_txn(4'd1, 32'd2, 32'd2, 4'd6, -1, 0);
      do_txn(4'd1, 32'd2, 32'd3, 4'd4, 15, 0);
`endif

      // Reset while waiting for a response; the late answer is spurious.
      wait_ready();
      host_if.req_valid = 1'b1;
      host_if.req_cmd   = 4'd1;
      host_if.req_op1   = 32'd1;
      host_if.req_op2   = 32'd1;
      host_if.req_tag   = 4'd12;
      @(negedge c_clk);
      host_if.req_valid = 1'b0;
      repeat (3) @(negedge c_clk);
      reset = 1'b1;
      @(negedge c_clk);
      reset = 1'b0;
      check("abort_valid", 64'(host_if.rsp_valid), 64'd0);
      check("abort_cmd", 64'(dut_cmd), 64'd0);
      check("abort_data", 64'(dut_data), 64'd0);
      dut_resp  = 2'b01;
      dut_rdata = 32'd2;
      @(negedge c_clk);
      dut_resp  = 2'b00;
      dut_rdata = 32'd0;
      check("late_no_valid", 64'(host_if.rsp_valid), 64'd0);
      check("spur_set", 64'(err_spurious), 64'd1);
      do_txn(4'd1, 32'd40, 32'd2, 4'd11, 1, 0);
      check("spur_sticky", 64'(err_spurious), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
